// File: rtl/quadtree_switch_scheduler.sv
// Registered round-robin multicast switch scheduler for the quadtree router.
// Ports NW, NE, SE, SW, LOCAL map to indices 0..4. A request is granted only
// as a whole: every output in its mask at once, or nothing.
// Optional build macro: QT_SCHED_STARVE_EN enables per-input wait counters
// and starvation priority for wide broadcasts.

`ifdef QT_SCHED_STARVE_EN
// Per-input saturating wait counter; counts cycles spent requesting without a grant.
module qts_wait_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt
);
    logic [CNT_W-1:0] r_cnt;

    // Clear when idle or served, otherwise count up and stick at all-ones.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                r_cnt <= '0;
        else if (!i_req || i_clr) r_cnt <= '0;
        else if (r_cnt != '1)     r_cnt <= r_cnt + 1'b1;
    end

    assign o_cnt = r_cnt;
endmodule
`endif

module quadtree_switch_scheduler #(
    parameter int DIRECTION    = 5,
    parameter int STARVE_LIMIT = 15,
    parameter int CNT_W        = 4
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [DIRECTION-1:0]           i_sa_request,
    input  logic [DIRECTION*DIRECTION-1:0] i_sa_port,
    input  logic [DIRECTION-1:0]           i_credit_avail,
    output logic [DIRECTION-1:0]           o_sa_grant,
    output logic [DIRECTION*DIRECTION-1:0] o_st_ctrl,
    output logic [DIRECTION-1:0]           o_out_unit_en,
    output logic [2:0]                     o_prio_ptr
);
    logic [DIRECTION-1:0][DIRECTION-1:0] w_mask;
    logic [DIRECTION-1:0][DIRECTION-1:0] w_st_next;
    logic [DIRECTION-1:0][DIRECTION-1:0] r_st;
    logic [DIRECTION-1:0]                w_out_ok;
    logic [DIRECTION-1:0]                w_elig;
    logic [DIRECTION-1:0]                w_grant;
    logic [DIRECTION-1:0]                w_used;
    logic [DIRECTION-1:0]                w_busy;
    logic [DIRECTION-1:0]                r_grant;
    logic [DIRECTION-1:0]                r_out_en;
    logic [2:0]                          r_ptr;
    logic [2:0]                          w_start;
    logic [2:0]                          w_first;
    logic [2:0]                          w_ptr_next;
    logic                                w_found;
    logic                                w_starve_any;
    logic [2:0]                          w_starve_idx;

    assign w_mask = i_sa_port;

    // An output just granted last cycle still has a stale credit, so skip it.
    assign w_out_ok = i_credit_avail & ~r_out_en;

    genvar g;
    generate
        for (g = 0; g < DIRECTION; g++) begin : g_lane
            // An input just granted still shows its request for one more cycle.
            assign w_elig[g]    = i_sa_request[g] & ~r_grant[g] & ~|(w_mask[g] & ~w_out_ok);
            assign w_st_next[g] = w_grant[g] ? w_mask[g] : '0;
        end
    endgenerate

`ifdef QT_SCHED_STARVE_EN
    logic [DIRECTION-1:0][CNT_W-1:0] w_cnt;
    logic [DIRECTION-1:0]            w_starved;

    generate
        for (g = 0; g < DIRECTION; g++) begin : g_wait
            qts_wait_cnt #(.CNT_W(CNT_W)) u_cnt (
                .i_clk (i_clk),
                .i_rst (i_rst),
                .i_req (i_sa_request[g]),
                .i_clr (w_grant[g] | r_grant[g]),
                .o_cnt (w_cnt[g])
            );
            assign w_starved[g] = (int'(w_cnt[g]) >= STARVE_LIMIT);
        end
    endgenerate

    // Lowest-index starved input takes the head of the visit order.
    always_comb begin
        w_starve_any = |w_starved;
        w_starve_idx = '0;
        for (int i = DIRECTION - 1; i >= 0; i--) begin
            if (w_starved[i]) w_starve_idx = 3'(i);
        end
    end
`else
    logic [31:0] w_unused_cfg;
    assign w_unused_cfg = STARVE_LIMIT ^ CNT_W;
    assign w_starve_any = 1'b0;
    assign w_starve_idx = '0;
`endif

    // Walk inputs from the start index, accepting eligible, non-overlapping masks.
    // A starved head reserves its outputs even when it cannot be served itself.
    always_comb begin
        logic [3:0] sum;
        logic [2:0] idx;
        sum     = '0;
        idx     = '0;
        w_start = w_starve_any ? w_starve_idx : r_ptr;
        w_busy  = w_starve_any ? w_mask[w_starve_idx] : '0;
        w_grant = '0;
        w_used  = '0;
        w_found = 1'b0;
        w_first = r_ptr;
        for (int k = 0; k < DIRECTION; k++) begin
            sum = {1'b0, w_start} + 4'(k);
            if (sum >= 4'(DIRECTION)) sum = sum - 4'(DIRECTION);
            idx = sum[2:0];
            if (w_elig[idx] && (k == 0 || !(|(w_mask[idx] & w_busy)))) begin
                w_grant[idx] = 1'b1;
                w_busy       = w_busy | w_mask[idx];
                w_used       = w_used | w_mask[idx];
                if (!w_found) begin
                    w_found = 1'b1;
                    w_first = idx;
                end
            end
        end
    end

    // Pointer moves just past the first input served this cycle.
    always_comb begin
        w_ptr_next = r_ptr;
        if (w_found) w_ptr_next = (w_first == 3'(DIRECTION - 1)) ? 3'd0 : w_first + 3'd1;
    end

    // Register grants, switch control, output enables and the pointer.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_grant  <= '0;
            r_st     <= '0;
            r_out_en <= '0;
            r_ptr    <= '0;
        end else begin
            r_grant  <= w_grant;
            r_st     <= w_st_next;
            r_out_en <= w_used;
            r_ptr    <= w_ptr_next;
        end
    end

    assign o_sa_grant    = r_grant;
    assign o_st_ctrl     = r_st;
    assign o_out_unit_en = r_out_en;
    assign o_prio_ptr    = r_ptr;
endmodule
